// File: rtl/generador_codigo_6bit.sv
// Serial 6-bit line-code generator: symbol index in, MSB-first frame out with frame strobe.
// Optional odd-parity seventh bit enabled by defining PARIDAD_EN.
module generador_codigo_6bit (
  input  logic       Reloj,
  input  logic       ResetN,
  input  logic [4:0] Dato,
  input  logic       DatoValido,
  output logic       Listo,
  output logic       SalidaSerie,
  output logic       Trama,
  output logic       Ocupado,
  output logic       Error
);

`ifdef PARIDAD_EN
  localparam int unsigned N_BITS = 7;
`else
  localparam int unsigned N_BITS = 6;
`endif
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CODE_W   = 6;
  localparam int unsigned LAST_IDX = 21;

  typedef enum logic {INACTIVO, TRANSMITE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BITS-1:0]   shreg_q, shreg_d;
  logic                serie_q, serie_d;
  logic                trama_q, trama_d;
  logic                ocup_q, ocup_d;
  logic                error_q, error_d;

  logic [CODE_W-1:0]   code_c;
  logic [N_BITS-1:0]   frame_c;
  logic                legal_c;
  logic                last_bit_c;
  logic                xfer_c;

  // Index to legal line-code table
  always_comb begin
    code_c = '0;
    case (Dato)
      5'd0:  code_c = 6'd1;
      5'd1:  code_c = 6'd2;
      5'd2:  code_c = 6'd3;
      5'd3:  code_c = 6'd5;
      5'd4:  code_c = 6'd10;
      5'd5:  code_c = 6'd12;
      5'd6:  code_c = 6'd13;
      5'd7:  code_c = 6'd15;
      5'd8:  code_c = 6'd20;
      5'd9:  code_c = 6'd21;
      5'd10: code_c = 6'd22;
      5'd11: code_c = 6'd23;
      5'd12: code_c = 6'd25;
      5'd13: code_c = 6'd30;
      5'd14: code_c = 6'd31;
      5'd15: code_c = 6'd32;
      5'd16: code_c = 6'd33;
      5'd17: code_c = 6'd35;
      5'd18: code_c = 6'd50;
      5'd19: code_c = 6'd51;
      5'd20: code_c = 6'd52;
      5'd21: code_c = 6'd53;
      default: code_c = '0;
    endcase
  end

  always_comb begin
`ifdef PARIDAD_EN
    frame_c = {code_c, ~^code_c};
`else
    frame_c = code_c;
`endif
  end

  assign legal_c    = (Dato <= 5'(LAST_IDX));
  assign last_bit_c = (state_q == TRANSMITE) && (cnt_q == CNT_W'(N_BITS - 1));
  assign Listo      = (state_q == INACTIVO) || last_bit_c;
  assign xfer_c     = DatoValido && Listo;

  always_ff @(posedge Reloj or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= INACTIVO;
      cnt_q   <= '0;
      shreg_q <= '0;
      serie_q <= 1'b0;
      trama_q <= 1'b0;
      ocup_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      serie_q <= serie_d;
      trama_q <= trama_d;
      ocup_q  <= ocup_d;
      error_q <= error_d;
    end
  end

  // Next state: a frame ends on its last bit unless a legal symbol is taken there
  always_comb begin
    state_d = state_q;
    case (state_q)
      INACTIVO: begin
        if (xfer_c && legal_c) state_d = TRANSMITE;
      end
      TRANSMITE: begin
        if (last_bit_c) state_d = (xfer_c && legal_c) ? TRANSMITE : INACTIVO;
      end
      default: state_d = INACTIVO;
    endcase
  end

  // Shift register, bit counter and registered line outputs
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    serie_d = 1'b0;
    trama_d = 1'b0;
    ocup_d  = 1'b0;
    error_d = 1'b0;
    if (xfer_c && legal_c) begin
      serie_d = frame_c[N_BITS-1];
      shreg_d = frame_c << 1;
      cnt_d   = '0;
      trama_d = 1'b1;
      ocup_d  = 1'b1;
    end else if (xfer_c) begin
      error_d = 1'b1;
      cnt_d   = '0;
      shreg_d = '0;
    end else if ((state_q == TRANSMITE) && !last_bit_c) begin
      serie_d = shreg_q[N_BITS-1];
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      ocup_d  = 1'b1;
    end else begin
      cnt_d   = '0;
      shreg_d = '0;
    end
  end

  assign SalidaSerie = serie_q;
  assign Trama       = trama_q;
  assign Ocupado     = ocup_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_generador_codigo_6bit.sv
// Scoreboard bench for generador_codigo_6bit: stimulus pushes expected frames/errors,
// a negedge monitor pops and compares whatever the line presents.
module tb_generador_codigo_6bit;

`ifdef PARIDAD_EN
  localparam int unsigned N = 7;
`else
  localparam int unsigned N = 6;
`endif

  typedef struct packed {
    logic       is_err;
    logic [6:0] frame;
  } exp_t;

  logic       Reloj;
  logic       ResetN;
  logic [4:0] Dato;
  logic       DatoValido;
  logic       Listo;
  logic       SalidaSerie;
  logic       Trama;
  logic       Ocupado;
  logic       Error;

  exp_t exp_q[$];
  int   trama_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  generador_codigo_6bit dut (
    .Reloj      (Reloj),
    .ResetN     (ResetN),
    .Dato       (Dato),
    .DatoValido (DatoValido),
    .Listo      (Listo),
    .SalidaSerie(SalidaSerie),
    .Trama      (Trama),
    .Ocupado    (Ocupado),
    .Error      (Error)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] mk_frame(input logic [5:0] code);
`ifdef PARIDAD_EN
    return {code, ~^code};
`else
    return {1'b0, code};
`endif
  endfunction

  // Present a symbol, wait for Listo, and push the expected response at the transfer edge
  task automatic send(input logic [4:0] idx, input logic [5:0] code, input bit illegal);
    int t;
    exp_t e;
    @(negedge Reloj);
    Dato       = idx;
    DatoValido = 1'b1;
    t = 0;
    while (!Listo && t < 50) begin
      @(negedge Reloj);
      t++;
    end
    if (!Listo) begin
      chk("listo_timeout", 32'(Listo), 32'd1);
      return;
    end
    @(posedge Reloj);
    e.is_err = illegal;
    e.frame  = illegal ? 7'd0 : mk_frame(code);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge Reloj);
    DatoValido = 1'b0;
    repeat (n) @(negedge Reloj);
  endtask

  // Monitor: checks frames, error pulses, Listo and idle line every cycle
  initial begin
    int         pos;
    int         cyc;
    bit         coll;
    logic [6:0] got;
    exp_t       e;
    pos  = 0;
    cyc  = 0;
    coll = 1'b0;
    got  = '0;
    forever begin
      @(negedge Reloj);
      cyc++;
      if (!ResetN) begin
        coll = 1'b0;
        continue;
      end
      if (Error) begin
        if (exp_q.size() == 0) chk("unexpected_error", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("error_kind", 32'(e.is_err), 32'd1);
        end
      end
      if (Trama && coll) begin
        chk("truncated_frame", 32'(pos), 32'(N));
        coll = 1'b0;
      end
      if (Trama) begin
        coll = 1'b1;
        pos  = 0;
        got  = '0;
        trama_cyc.push_back(cyc);
      end
      if (coll) begin
        chk("busy", 32'(Ocupado), 32'd1);
        chk("listo_in_frame", 32'(Listo), 32'(pos == int'(N) - 1));
        got = {got[5:0], SalidaSerie};
        pos++;
        if (pos == int'(N)) begin
          coll = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_frame", 32'(got), 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("frame_kind", 32'(e.is_err), 32'd0);
            chk("frame_bits", 32'(got), 32'(e.frame));
          end
        end
      end else begin
        chk("idle_line", 32'(SalidaSerie), 32'd0);
        chk("idle_busy", 32'(Ocupado), 32'd0);
        chk("idle_listo", 32'(Listo), 32'd1);
      end
    end
  end

  initial begin
    ResetN     = 1'b0;
    Dato       = '0;
    DatoValido = 1'b0;
    repeat (3) @(negedge Reloj);
    chk("rst_serie", 32'(SalidaSerie), 32'd0);
    chk("rst_trama", 32'(Trama), 32'd0);
    chk("rst_busy", 32'(Ocupado), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_listo", 32'(Listo), 32'd1);
    ResetN = 1'b1;
    idle(2);

    // Single symbol
    send(5'd0, 6'b000001, 1'b0);
    idle(10);

    // Back-to-back frames with no gap
    send(5'd21, 6'b110101, 1'b0);
    send(5'd13, 6'b011110, 1'b0);
    idle(12);
    if (trama_cyc.size() >= 2)
      chk("b2b_period", 32'(trama_cyc[trama_cyc.size()-1] - trama_cyc[trama_cyc.size()-2]), 32'(N));
    else
      chk("b2b_trama_count", 32'(trama_cyc.size()), 32'd2);

    // Illegal indices from idle, then a legal one
    send(5'd22, 6'b000000, 1'b1);
    send(5'd31, 6'b000000, 1'b1);
    idle(3);
    send(5'd17, 6'b100011, 1'b0);
    idle(10);

    // Illegal index taken on the last bit cycle
    send(5'd3, 6'b000101, 1'b0);
    send(5'd25, 6'b000000, 1'b1);
    idle(5);

    // Parity-relevant code and a back-to-back pair
    send(5'd7, 6'b001111, 1'b0);
    send(5'd9, 6'b010101, 1'b0);
    idle(12);
    chk("b2b_period_2", 32'(trama_cyc[trama_cyc.size()-1] - trama_cyc[trama_cyc.size()-2]), 32'(N));

    // Reset in the middle of a frame
    send(5'd19, 6'b110011, 1'b0);
    repeat (3) @(posedge Reloj);
    #2;
    chk("pre_rst_busy", 32'(Ocupado), 32'd1);
    ResetN     = 1'b0;
    DatoValido = 1'b0;
    #1;
    chk("abort_serie", 32'(SalidaSerie), 32'd0);
    chk("abort_busy", 32'(Ocupado), 32'd0);
    chk("abort_trama", 32'(Trama), 32'd0);
    chk("abort_listo", 32'(Listo), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge Reloj);
    ResetN = 1'b1;
    idle(8);
    send(5'd20, 6'b110100, 1'b0);
    idle(10);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
